response_framer: RTL and testbench

RESPONSE_FRAMER -- requirements
Module: response_framer

---
 rtl/response_framer.sv | 205 ++++++++++++++++++++
 tb/tb_response_framer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/response_framer.sv
// Frames a command response for a byte-wide UART: AA 55 cmd len_hi len_lo payload [checksum].
// Optional feature macro: RESP_CHECKSUM_EN appends the modulo-256 checksum byte.
module response_framer #(
    parameter int MAX_PAYLOAD_LEN = 256,
    parameter int ADDR_W          = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [7:0]        req_cmd,
    input  logic [15:0]       req_len,
    output logic [ADDR_W-1:0] payload_rd_addr,
    input  logic [7:0]        payload_rd_data,
    output logic [7:0]        tx_data_in,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              frame_done,
    output logic              frame_error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FETCH = 3'd2,
        S_SEND  = 3'd3,
        S_GUARD = 3'd4,
        S_WAIT  = 3'd5
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(MAX_PAYLOAD_LEN);
`ifdef RESP_CHECKSUM_EN
    localparam logic [16:0] LAST_OFS = 17'd5;
`else
    localparam logic [16:0] LAST_OFS = 17'd4;
`endif

    state_t              state_r;
    state_t              state_next_s;
    logic [16:0]         idx_r;
    logic [16:0]         last_idx_r;
    logic [7:0]          cmd_r;
    logic [15:0]         len_r;
    logic [7:0]          tx_data_r;
    logic [ADDR_W-1:0]   addr_r;
    logic                ready_r;
    logic                tx_start_r;
    logic                frame_done_r;
    logic                frame_error_r;
    logic [16:0]         payload_end_s;
    logic                is_payload_s;
    logic                too_long_s;
    logic                accept_s;
    logic [7:0]          cur_byte_s;
`ifdef RESP_CHECKSUM_EN
    logic [7:0]          chk_r;
    logic                in_sum_s;
`endif

    assign req_ready       = ready_r;
    assign payload_rd_addr = addr_r;
    assign tx_data_in      = tx_data_r;
    assign tx_start        = tx_start_r;
    assign frame_done      = frame_done_r;
    assign frame_error     = frame_error_r;

    // Byte selection and next-state decode.
    always_comb begin
        state_next_s  = state_r;
        cur_byte_s    = 8'h00;
        payload_end_s = {1'b0, len_r} + 17'd5;
        is_payload_s  = (idx_r >= 17'd5) && (idx_r < payload_end_s);
        too_long_s    = ({1'b0, req_len} > MAX_LEN);
        accept_s      = req_valid && ready_r;
`ifdef RESP_CHECKSUM_EN
        in_sum_s      = (idx_r >= 17'd2) && (idx_r < payload_end_s);
`endif
        case (idx_r)
            17'd0:   cur_byte_s = 8'hAA;
            17'd1:   cur_byte_s = 8'h55;
            17'd2:   cur_byte_s = cmd_r;
            17'd3:   cur_byte_s = len_r[15:8];
            17'd4:   cur_byte_s = len_r[7:0];
            default: begin
`ifdef RESP_CHECKSUM_EN
                if (is_payload_s) begin
                    cur_byte_s = payload_rd_data;
                end else begin
                    cur_byte_s = chk_r;
                end
`else
                cur_byte_s = payload_rd_data;
`endif
            end
        endcase

        case (state_r)
            S_IDLE: begin
                if (accept_s && !too_long_s) begin
                    state_next_s = S_LOAD;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_LOAD: begin
                if (is_payload_s) begin
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_SEND;
                end
            end
            S_FETCH: state_next_s = S_SEND;
            S_SEND: begin
                if (!tx_busy) begin
                    state_next_s = S_GUARD;
                end else begin
                    state_next_s = S_SEND;
                end
            end
            // The UART needs a cycle to raise tx_busy after the strobe.
            S_GUARD: state_next_s = S_WAIT;
            S_WAIT: begin
                if (tx_busy) begin
                    state_next_s = S_WAIT;
                end else if (idx_r == last_idx_r) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_LOAD;
                end
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // State, datapath and registered strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            idx_r         <= 17'd0;
            last_idx_r    <= 17'd0;
            cmd_r         <= 8'h00;
            len_r         <= 16'h0000;
            tx_data_r     <= 8'h00;
            addr_r        <= '0;
            ready_r       <= 1'b0;
            tx_start_r    <= 1'b0;
            frame_done_r  <= 1'b0;
            frame_error_r <= 1'b0;
`ifdef RESP_CHECKSUM_EN
            chk_r         <= 8'h00;
`endif
        end else begin
            state_r       <= state_next_s;
            ready_r       <= (state_next_s == S_IDLE);
            tx_start_r    <= 1'b0;
            frame_done_r  <= 1'b0;
            frame_error_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        if (too_long_s) begin
                            frame_error_r <= 1'b1;
                        end else begin
                            cmd_r      <= req_cmd;
                            len_r      <= req_len;
                            idx_r      <= 17'd0;
                            last_idx_r <= {1'b0, req_len} + LAST_OFS;
`ifdef RESP_CHECKSUM_EN
                            chk_r      <= 8'h00;
`endif
                        end
                    end
                end
                S_LOAD: begin
                    if (is_payload_s) begin
                        addr_r <= ADDR_W'(idx_r - 17'd5);
                    end
                end
                S_SEND: begin
                    if (!tx_busy) begin
                        tx_data_r  <= cur_byte_s;
                        tx_start_r <= 1'b1;
`ifdef RESP_CHECKSUM_EN
                        if (in_sum_s) begin
                            chk_r <= chk_r + cur_byte_s;
                        end
`endif
                    end
                end
                S_WAIT: begin
                    if (!tx_busy) begin
                        if (idx_r == last_idx_r) begin
                            frame_done_r <= 1'b1;
                        end else begin
                            idx_r <= idx_r + 17'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_response_framer.sv
// Scoreboard bench for response_framer: a request monitor pushes the expected frame,
// a UART-side monitor pops and compares each transmitted byte.
module tb_response_framer;

    localparam int MAXL = 256;
    localparam int AW   = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [7:0]    req_cmd = 8'h00;
    logic [15:0]   req_len = 16'h0000;
    logic [AW-1:0] payload_rd_addr;
    logic [7:0]    payload_rd_data;
    logic [7:0]    tx_data_in;
    logic          tx_start;
    logic          tx_busy;
    logic          frame_done;
    logic          frame_error;

    always #5 clk = ~clk;

    response_framer #(.MAX_PAYLOAD_LEN(MAXL), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_len(req_len), .payload_rd_addr(payload_rd_addr),
        .payload_rd_data(payload_rd_data), .tx_data_in(tx_data_in), .tx_start(tx_start),
        .tx_busy(tx_busy), .frame_done(frame_done), .frame_error(frame_error)
    );

    // Payload buffer with one-cycle read latency and a simple UART busy model.
    logic [7:0] mem [0:255];
    int busy_len = 3;
    int busy_cnt = 0;
    always @(posedge clk) payload_rd_data <= mem[payload_rd_addr];
    always @(posedge clk) begin
        if (tx_start) busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    logic [7:0] exp_q[$];
    int addr_log[$];
    int checks = 0, errors = 0;
    int tx_cnt = 0, accept_cnt = 0, done_cnt = 0, frames_open = 0;
    bit err_next = 1'b0;
    logic [7:0] last_tx = 8'h00;

`ifdef RESP_CHECKSUM_EN
    localparam int HAS_CHK = 1;
`else
    localparam int HAS_CHK = 0;
`endif

    // Reference model: the frame is header, payload read from the buffer, then the byte sum.
    function automatic void push_frame(input logic [7:0] c, input logic [15:0] l);
        int sum;
        logic [7:0] b;
        sum = int'(c) + int'(l[15:8]) + int'(l[7:0]);
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        exp_q.push_back(c);
        exp_q.push_back(l[15:8]);
        exp_q.push_back(l[7:0]);
        for (int i = 0; i < int'(l); i++) begin
            b = mem[i % 256];
            sum = sum + int'(b);
            exp_q.push_back(b);
        end
        if (HAS_CHK != 0) exp_q.push_back(8'(sum % 256));
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: accepts, transmitted bytes, frame_done and frame_error.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_start) begin
                tx_cnt++;
                last_tx = tx_data_in;
                addr_log.push_back(int'(payload_rd_addr));
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_tx: got byte 0x%02h, required no transmission", tx_data_in);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_data_in !== e) begin
                        errors++;
                        $display("FAIL tx_byte: got 0x%02h, required 0x%02h", tx_data_in, e);
                    end
                end
            end
            if (frame_done) begin
                done_cnt++;
                checks++;
                if (frames_open == 0 || exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL frame_done: got pulse with %0d bytes pending and %0d open frames, required 0 pending and 1 open",
                             exp_q.size(), frames_open);
                end else begin
                    frames_open--;
                end
            end
            if (frame_error || err_next) begin
                checks++;
                if (frame_error !== err_next) begin
                    errors++;
                    $display("FAIL frame_error_timing: got %0b, required %0b", frame_error, err_next);
                end
            end
            err_next = 1'b0;
            if (req_valid && req_ready) begin
                accept_cnt++;
                if (int'(req_len) > MAXL) begin
                    err_next = 1'b1;
                end else begin
                    push_frame(req_cmd, req_len);
                    frames_open++;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!req_ready && t < 2000) begin
            tick(1);
            t++;
        end
        chk("ready_timeout", int'(req_ready), 1);
    endtask

    task automatic wait_done();
        int t = 0;
        while (!frame_done && t < 20000) begin
            tick(1);
            t++;
        end
        chk("done_timeout", int'(frame_done), 1);
    endtask

    task automatic issue(input logic [7:0] c, input logic [15:0] l);
        wait_ready();
        req_valid = 1'b1;
        req_cmd   = c;
        req_len   = l;
        tick(1);
        req_valid = 1'b0;
        if (int'(l) > MAXL) tick(1);
        else wait_done();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, int'(req_ready), 0);
        chk({tag, "_tx_start"}, int'(tx_start), 0);
        chk({tag, "_done"}, int'(frame_done), 0);
        chk({tag, "_error"}, int'(frame_error), 0);
        chk({tag, "_tx_data"}, int'(tx_data_in), 0);
        chk({tag, "_addr"}, int'(payload_rd_addr), 0);
    endtask

    initial begin
        int t0, d0, a0, t;
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        // Reset values, then ready one cycle after release.
        rst_n = 1'b0;
        tick(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick(1);
        chk("ready_after_reset", int'(req_ready), 1);

        // cmd=01, len=0 with a slow UART.
        busy_len = 10;
        t0 = tx_cnt; d0 = done_cnt;
        issue(8'h01, 16'd0);
        tick(5);
        chk("len0_bytes", tx_cnt - t0, 5 + HAS_CHK);
        chk("len0_last", int'(last_tx), (HAS_CHK != 0) ? 32'h01 : 32'h00);
        chk("len0_done_once", done_cnt - d0, 1);

        // cmd=10, len=3, payload 11 22 33.
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
        busy_len = 2;
        t0 = tx_cnt;
        addr_log.delete();
        issue(8'h10, 16'd3);
        tick(3);
        chk("len3_bytes", tx_cnt - t0, 8 + HAS_CHK);
        chk("len3_last", int'(last_tx), (HAS_CHK != 0) ? 32'h79 : 32'h33);
        chk("len3_addr0", (addr_log.size() > 7) ? addr_log[5] : -1, 0);
        chk("len3_addr1", (addr_log.size() > 7) ? addr_log[6] : -1, 1);
        chk("len3_addr2", (addr_log.size() > 7) ? addr_log[7] : -1, 2);

        // Over-length request is rejected without transmission.
        t0 = tx_cnt;
        wait_ready();
        req_valid = 1'b1; req_cmd = 8'h5A; req_len = 16'd257;
        tick(1);
        req_valid = 1'b0;
        chk("err_pulse", int'(frame_error), 1);
        chk("err_ready_kept", int'(req_ready), 1);
        tick(1);
        chk("err_pulse_one_cycle", int'(frame_error), 0);
        tick(5);
        chk("err_no_tx", tx_cnt - t0, 0);
        chk("err_ready_after", int'(req_ready), 1);

        // Maximum-length frame.
        busy_len = 1;
        t0 = tx_cnt;
        issue(8'h33, 16'(MAXL));
        tick(3);
        chk("maxlen_bytes", tx_cnt - t0, MAXL + 5 + HAS_CHK);

        // req_valid held high across two frames.
        busy_len = 2;
        a0 = accept_cnt; t0 = tx_cnt;
        wait_ready();
        req_cmd = 8'h42; req_len = 16'd2; req_valid = 1'b1;
        n = 0; t = 0;
        while (n < 2 && t < 5000) begin
            tick(1);
            t++;
            if (frame_done) n++;
        end
        req_valid = 1'b0;
        tick(3);
        chk("held_done_count", n, 2);
        chk("held_accepts", accept_cnt - a0, 2);
        chk("held_bytes", tx_cnt - t0, 2 * (7 + HAS_CHK));

        // Reset after the third byte abandons the frame.
        busy_len = 3;
        t0 = tx_cnt;
        wait_ready();
        req_valid = 1'b1; req_cmd = 8'h66; req_len = 16'd5;
        tick(1);
        req_valid = 1'b0;
        t = 0;
        while (tx_cnt - t0 < 3 && t < 2000) begin
            tick(1);
            t++;
        end
        chk("mid_reset_reached_3", tx_cnt - t0, 3);
        rst_n = 1'b0;
        exp_q.delete();
        frames_open = 0;
        err_next = 1'b0;
        tick(2);
        check_reset_outputs("mid_reset");
        rst_n = 1'b1;
        t0 = tx_cnt;
        tick(20);
        chk("mid_reset_no_tx", tx_cnt - t0, 0);
        t0 = tx_cnt;
        issue(8'h77, 16'd4);
        tick(3);
        chk("post_reset_bytes", tx_cnt - t0, 9 + HAS_CHK);

        // Randomized frames, occasionally over-length.
        for (int k = 0; k < 12; k++) begin
            logic [15:0] l;
            busy_len = int'($urandom_range(1, 6));
            if ($urandom_range(0, 5) == 0) l = 16'($urandom_range(257, 400));
            else l = 16'($urandom_range(0, 12));
            issue(8'($urandom), l);
        end
        tick(10);
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_frames_open", frames_open, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
